// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the memory game symbol path.
package memory_game_pkg;

    localparam int unsigned N_BTN = 8;
    localparam int unsigned SYM_W = 3;

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [N_BTN-1:0] btn_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } btn_enc_state_t;

    // True when exactly one bit of v is set.
    function automatic logic onehot_ok(input btn_t v);
        return (v != '0) && ((v & (v - btn_t'(1))) == '0);
    endfunction

    // Index of the set bit of a one-hot vector (OR of the indices of set bits).
    function automatic sym_t oh2idx(input btn_t v);
        sym_t idx;
        idx = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (v[i]) begin
                idx = idx | sym_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_encoder_if.sv
// Button/symbol bundle between the player controls and the input handler.
interface button_encoder_if #(
    parameter int unsigned N_BTN = memory_game_pkg::N_BTN,
    parameter int unsigned SYM_W = memory_game_pkg::SYM_W
) ();

    logic             en;
    logic [N_BTN-1:0] btn;
    logic             sym_valid;
    logic [SYM_W-1:0] sym;
    logic             multi_press;
    logic [N_BTN-1:0] btn_led;

    // Player/consumer side: drives buttons and enable, receives symbols.
    modport master (
        output en,
        output btn,
        input  sym_valid,
        input  sym,
        input  multi_press,
        input  btn_led
    );

    // Encoder side.
    modport slave (
        input  en,
        input  btn,
        output sym_valid,
        output sym,
        output multi_press,
        output btn_led
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, reset to zero.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_encoder.sv
// Turns raw push buttons into debounced, one-hot-checked symbol strobes.
module button_encoder
    import memory_game_pkg::*;
#(
    parameter int unsigned N_BTN           = memory_game_pkg::N_BTN,
    parameter int unsigned SYM_W           = memory_game_pkg::SYM_W,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    button_encoder_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_BTN-1:0] s;

    btn_enc_state_t   state_q, state_d;
    logic [N_BTN-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic             multi_q, multi_d;
    logic [N_BTN-1:0] led_q, led_d;

    sync2 #(.WIDTH(N_BTN)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.btn),
        .q_o   (s)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            multi_q     <= 1'b0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            multi_q     <= multi_d;
            led_q       <= led_d;
        end
    end

    // Debounce press/release; the counter only advances below CNT_MAX, so it never wraps.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        led_d       = led_q;
        sym_valid_d = 1'b0;
        multi_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en && (s != '0)) begin
                    vec_d   = s;
                    cnt_d   = CNT_ONE;
                    state_d = PRESS_DB;
                end
            end

            PRESS_DB: begin
                if (!bus.en) begin
                    // Disabled mid-debounce: wait for a full release so a later
                    // re-enable cannot emit the press that started while enabled.
                    cnt_d   = '0;
                    state_d = REL_DB;
                end else if (s != vec_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (onehot_ok(vec_q)) begin
                        sym_valid_d = 1'b1;
                        sym_d       = oh2idx(vec_q);
                        led_d       = vec_q;
                        state_d     = HELD;
                    end else begin
                        multi_d = 1'b1;
                        state_d = REL_DB;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            HELD: begin
                if (s == '0) begin
                    cnt_d   = CNT_ONE;
                    state_d = REL_DB;
                end
            end

            REL_DB: begin
                if (s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    led_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.sym_valid   = sym_valid_q;
    assign bus.sym         = sym_q;
    assign bus.multi_press = multi_q;
    assign bus.btn_led     = led_q;

endmodule

// File: tb/tb_button_encoder.sv
// Self-checking bench for button_encoder with DEBOUNCE_CYCLES=4.
module tb_button_encoder;

    localparam int DC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    button_encoder_if bus_if ();

    button_encoder #(
        .N_BTN           (8),
        .SYM_W           (3),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] btn;
        logic       en;
        int         hold;
        int         exp_valid;
        int         exp_multi;
        logic [2:0] exp_sym;
    } vec_t;

    vec_t tbl[10];

    // Behavioural reference: press acceptance described as free / counting / locked.
    localparam int M_FREE   = 0;
    localparam int M_COUNT  = 1;
    localparam int M_LOCKED = 2;

    logic [7:0] m_s1, m_s2, m_cand, m_led;
    logic [2:0] m_sym;
    logic       m_valid, m_multi;
    int         m_mode, m_run, m_zrun;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int nv, output int nm, output int first_v);
        nv = 0;
        nm = 0;
        first_v = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus_if.sym_valid) begin
                if (nv == 0) first_v = i;
                nv++;
            end
            if (bus_if.multi_press) nm++;
        end
    endtask

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cand = '0; m_led = '0; m_sym = '0;
        m_valid = 1'b0; m_multi = 1'b0;
        m_mode = M_FREE; m_run = 0; m_zrun = 0;
    endtask

    task automatic model_edge(input logic en_v, input logic [7:0] btn_v);
        logic [7:0] s;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_v;
        m_valid = 1'b0;
        m_multi = 1'b0;
        if (m_mode == M_FREE) begin
            if (en_v && s != 0) begin
                m_mode = M_COUNT; m_cand = s; m_run = 1;
            end
        end else if (m_mode == M_COUNT) begin
            if (!en_v) begin
                m_mode = M_LOCKED; m_zrun = 0;
            end else if (s != m_cand) begin
                m_mode = M_FREE;
            end else if (m_run == DC) begin
                if ($countones(m_cand) == 1) begin
                    m_valid = 1'b1; m_sym = lowest_idx(m_cand); m_led = m_cand;
                end else begin
                    m_multi = 1'b1;
                end
                m_mode = M_LOCKED; m_zrun = 0;
            end else begin
                m_run++;
            end
        end else begin
            if (s != 0) m_zrun = 0;
            else if (m_zrun == DC) begin
                m_mode = M_FREE; m_led = '0;
            end else m_zrun++;
        end
    endtask

    initial begin
        int nv, nm, fv, nv2, nm2, fv2, first_zero, seg;

        tbl[0] = '{8'h20, 1'b1, 20,  1, 0, 3'd5};
        tbl[1] = '{8'h81, 1'b1, 10,  0, 1, 3'd5};
        tbl[2] = '{8'h04, 1'b1, 10,  1, 0, 3'd2};
        tbl[3] = '{8'h80, 1'b1, 100, 1, 0, 3'd7};
        tbl[4] = '{8'h80, 1'b1, 10,  1, 0, 3'd7};
        tbl[5] = '{8'h01, 1'b1, 4,   0, 0, 3'd7};
        tbl[6] = '{8'h02, 1'b1, 5,   1, 0, 3'd1};
        tbl[7] = '{8'h08, 1'b0, 10,  0, 0, 3'd1};
        tbl[8] = '{8'h03, 1'b1, 10,  0, 1, 3'd1};
        tbl[9] = '{8'hFF, 1'b1, 10,  0, 1, 3'd1};

        bus_if.en  = 1'b0;
        bus_if.btn = '0;

        // Reset state
        #2 rst_n = 1'b0;
        tick(); tick(); tick();
        chk("reset_valid", 32'(bus_if.sym_valid), 32'd0);
        chk("reset_sym",   32'(bus_if.sym),       32'd0);
        chk("reset_multi", 32'(bus_if.multi_press), 32'd0);
        chk("reset_led",   32'(bus_if.btn_led),   32'd0);
        rst_n = 1'b1;
        bus_if.en = 1'b1;
        tick(); tick();

        // Clean press: latency and LED echo
        bus_if.btn = 8'h20;
        run(20, nv, nm, fv);
        chk("clean_count", 32'(nv), 32'd1);
        chk("clean_latency", 32'(fv), 32'd6);
        chk("clean_sym", 32'(bus_if.sym), 32'd5);
        chk("clean_led_held", 32'(bus_if.btn_led), 32'h20);
        bus_if.btn = '0;
        first_zero = -1;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (first_zero < 0 && bus_if.btn_led == '0) first_zero = j;
        end
        chk("clean_led_release", 32'(first_zero), 32'd6);

        // Bounce then stable hold
        nv2 = 0;
        for (int k = 0; k < 6; k++) begin
            bus_if.btn = (k % 2 == 0) ? 8'h01 : 8'h00;
            run(2, nv, nm, fv);
            nv2 += nv;
        end
        chk("bounce_no_strobe", 32'(nv2), 32'd0);
        bus_if.btn = 8'h01;
        run(20, nv, nm, fv);
        chk("bounce_count", 32'(nv), 32'd1);
        chk("bounce_latency", 32'(fv), 32'd6);
        chk("bounce_sym", 32'(bus_if.sym), 32'd0);
        bus_if.btn = '0;
        run(12, nv, nm, fv);

        // Table-driven presses
        for (int t = 0; t < 10; t++) begin
            bus_if.en  = tbl[t].en;
            bus_if.btn = tbl[t].btn;
            run(tbl[t].hold, nv, nm, fv);
            bus_if.btn = '0;
            bus_if.en  = 1'b1;
            run(12, nv2, nm2, fv2);
            chk($sformatf("tbl%0d_valid", t), 32'(nv + nv2), 32'(tbl[t].exp_valid));
            chk($sformatf("tbl%0d_multi", t), 32'(nm + nm2), 32'(tbl[t].exp_multi));
            chk($sformatf("tbl%0d_sym", t),   32'(bus_if.sym), 32'(tbl[t].exp_sym));
            chk($sformatf("tbl%0d_led", t),   32'(bus_if.btn_led), 32'd0);
        end

        // en dropped mid-debounce, re-enabled while still held
        bus_if.en  = 1'b1;
        bus_if.btn = 8'h08;
        tick(); tick(); tick();
        bus_if.en = 1'b0;
        run(5, nv, nm, fv);
        bus_if.en = 1'b1;
        run(20, nv2, nm2, fv2);
        chk("en_gate_no_strobe", 32'(nv + nv2), 32'd0);
        bus_if.btn = '0;
        run(12, nv, nm, fv);
        bus_if.btn = 8'h08;
        run(10, nv, nm, fv);
        chk("en_gate_new_press", 32'(nv), 32'd1);
        chk("en_gate_sym", 32'(bus_if.sym), 32'd3);
        bus_if.btn = '0;
        run(12, nv, nm, fv);

        // Async reset while held
        bus_if.btn = 8'h10;
        run(10, nv, nm, fv);
        chk("rst_pre_led", 32'(bus_if.btn_led), 32'h10);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs",
            32'({bus_if.sym_valid, bus_if.sym, bus_if.multi_press, bus_if.btn_led}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        run(12, nv, nm, fv);
        chk("rst_repress_count", 32'(nv), 32'd1);
        chk("rst_repress_latency", 32'(fv), 32'd6);
        chk("rst_repress_sym", 32'(bus_if.sym), 32'd4);
        bus_if.btn = '0;
        run(12, nv, nm, fv);

        // Randomized run against the reference model
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        seg = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (seg == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)      bus_if.btn = '0;
                else if (r < 8) bus_if.btn = 8'(1 << $urandom_range(0, 7));
                else            bus_if.btn = 8'($urandom_range(0, 255));
                bus_if.en = ($urandom_range(0, 9) != 0);
                seg = $urandom_range(1, 12);
            end
            seg--;
            @(posedge clk);
            model_edge(bus_if.en, bus_if.btn);
            #1;
            chk("random",
                32'({bus_if.sym_valid, bus_if.sym, bus_if.multi_press, bus_if.btn_led}),
                32'({m_valid, m_sym, m_multi, m_led}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
